// File: rtl/cache_l1_pkg.sv
// Shared types and constants for the L1 data-cache load controller.
// Holds funct3 load codes, FSM state enum, block geometry and field helpers.
package cache_l1_pkg;

    localparam int BLOCK_W = 128;
    localparam int BEAT_W  = 32;
    localparam int BEATS   = 4;
    localparam int CNT_W   = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_FILL,
        S_RESPOND
    } state_t;

    function automatic int tag_w(input int addr_w, input int index_w);
        return addr_w - 4 - index_w;
    endfunction

    function automatic int index_lsb();
        return 4;
    endfunction

    // LD only rejects word 3 because the pair of words must stay in the block.
    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] off,
        input logic [1:0] word
    );
        logic m;
        m = 1'b0;
        case (f3)
            F3_LH, F3_LHU: m = (off == 2'd3);
            F3_LW, F3_LWU: m = (off != 2'd0);
            F3_LD:         m = (off != 2'd0) || (word == 2'd3);
            default:       m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cache_l1_load_ctrl_if.sv
// Core-side load request / response bundle for the L1 load controller.
// master = core (drives request, resp_ready), slave = controller.
interface cache_l1_load_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic [2:0]        req_funct3_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic              resp_err_o;
    logic [127:0]      ext_block_o;
    logic [1:0]        ext_offset_o;
    logic [1:0]        ext_word_o;
    logic [2:0]        ext_funct3_o;

    modport master (
        output req_valid_i, req_addr_i, req_funct3_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_err_o,
        input  ext_block_o, ext_offset_o, ext_word_o, ext_funct3_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_funct3_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_err_o,
        output ext_block_o, ext_offset_o, ext_word_o, ext_funct3_o
    );
endinterface

// File: rtl/cache_l1_refill_beats.sv
// Refill assembler: 2-bit beat counter plus 128-bit block register.
// Ports: clk_i, rst_ni, clr_i, en_i, beat_i -> block_o, done_o (4th beat).
module cache_l1_refill_beats
    import cache_l1_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [BEAT_W-1:0]  beat_i,
    output logic [BLOCK_W-1:0] block_o,
    output logic               done_o
);

    logic [CNT_W-1:0]   r_cnt;
    logic [BLOCK_W-1:0] r_block;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            r_cnt   <= '0;
            r_block <= '0;
        end else if (en_i) begin
            r_block[{r_cnt, 5'd0} +: BEAT_W] <= beat_i;
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign block_o = r_block;
    assign done_o  = en_i && (r_cnt == 2'd3);

endmodule

// File: rtl/cache_l1_load_ctrl.sv
// L1 D-cache load sequencer: lookup, L2 refill, fill, response to core.
// Ports: clk_i, rst_ni, core (slave if), arr_* array side, l2_* refill side.
// Optional macro CACHE_LOAD_MISALIGN_CHECK_EN enables misaligned-load errors.
module cache_l1_load_ctrl
    import cache_l1_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = tag_w(ADDR_W, INDEX_W)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    cache_l1_load_ctrl_if.slave core,
    output logic                arr_rd_en_o,
    output logic [INDEX_W-1:0]  arr_index_o,
    output logic [TAG_W-1:0]    arr_tag_o,
    input  logic                hit_i,
    input  logic [BLOCK_W-1:0]  arr_block_i,
    output logic                arr_wr_en_o,
    output logic [BLOCK_W-1:0]  arr_wr_block_o,
    output logic                l2_req_valid_o,
    input  logic                l2_req_ready_i,
    output logic [ADDR_W-1:0]   l2_addr_o,
    input  logic                l2_beat_valid_i,
    input  logic [BEAT_W-1:0]   l2_beat_i
);

    localparam int IL = index_lsb();

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [2:0]         r_funct3;
    logic [BLOCK_W-1:0] r_block;
    logic               w_accept;
    logic               w_flag;
    logic               w_beat_en;
    logic               w_clr;
    logic               w_done;
    logic [BLOCK_W-1:0] w_fill_block;
    logic               w_idle;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = core.req_valid_i && w_idle;

`ifdef CACHE_LOAD_MISALIGN_CHECK_EN
    logic r_err;

    assign w_flag = misaligned(core.req_funct3_i,
                               core.req_addr_i[1:0],
                               core.req_addr_i[3:2]);
    assign core.resp_err_o = r_err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_flag;
        end
    end
`else
    assign w_flag          = 1'b0;
    assign core.resp_err_o = 1'b0;
`endif

    // Assembler is cleared while idle so a refill always starts at beat 0.
    assign w_clr     = w_idle;
    assign w_beat_en = (r_state == S_REFILL) && l2_beat_valid_i;

    cache_l1_refill_beats u_beats (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (w_clr),
        .en_i    (w_beat_en),
        .beat_i  (l2_beat_i),
        .block_o (w_fill_block),
        .done_o  (w_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_block  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr   <= core.req_addr_i;
                r_funct3 <= core.req_funct3_i;
            end
            if (r_state == S_LOOKUP && hit_i) begin
                r_block <= arr_block_i;
            end
            if (r_state == S_FILL) begin
                r_block <= w_fill_block;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_flag ? S_RESPOND : S_LOOKUP;
                end
            end
            S_LOOKUP:   w_next = hit_i ? S_RESPOND : S_MISS_REQ;
            S_MISS_REQ: if (l2_req_ready_i) w_next = S_REFILL;
            S_REFILL:   if (w_done) w_next = S_FILL;
            S_FILL:     w_next = S_RESPOND;
            S_RESPOND:  if (core.resp_ready_i) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Index/tag come straight from the request in the accept cycle.
    always_comb begin
        arr_index_o = r_addr[IL+INDEX_W-1:IL];
        arr_tag_o   = r_addr[ADDR_W-1:IL+INDEX_W];
        if (w_idle) begin
            arr_index_o = core.req_addr_i[IL+INDEX_W-1:IL];
            arr_tag_o   = core.req_addr_i[ADDR_W-1:IL+INDEX_W];
        end
    end

    assign core.req_ready_o  = w_idle;
    assign arr_rd_en_o       = rst_ni && w_accept && !w_flag;
    assign arr_wr_en_o       = rst_ni && (r_state == S_FILL);
    assign arr_wr_block_o    = w_fill_block;
    assign l2_req_valid_o    = (r_state == S_MISS_REQ);
    assign l2_addr_o         = {r_addr[ADDR_W-1:IL], 4'b0};
    assign core.resp_valid_o = (r_state == S_RESPOND);
    assign core.ext_block_o  = r_block;
    assign core.ext_offset_o = r_addr[1:0];
    assign core.ext_word_o   = r_addr[3:2];
    assign core.ext_funct3_o = r_funct3;

endmodule

// File: tb/tb_cache_l1_load_ctrl.sv
// Scoreboard bench for cache_l1_load_ctrl: random loads vs a cache/memory
// model, plus directed hit, miss, backpressure, back-to-back and reset cases.
module tb_cache_l1_load_ctrl;

    typedef struct {
        logic [127:0] blk;
        logic [1:0]   off;
        logic [1:0]   word;
        logic [2:0]   f3;
        logic         err;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         arr_rd_en_o;
    logic [5:0]   arr_index_o;
    logic [21:0]  arr_tag_o;
    logic         hit_i;
    logic [127:0] arr_block_i;
    logic         arr_wr_en_o;
    logic [127:0] arr_wr_block_o;
    logic         l2_req_valid_o;
    logic         l2_req_ready_i;
    logic [31:0]  l2_addr_o;
    logic         l2_beat_valid_i;
    logic [31:0]  l2_beat_i;

    cache_l1_load_ctrl_if #(.ADDR_W(32)) core();

    cache_l1_load_ctrl #(.ADDR_W(32), .INDEX_W(6)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .core            (core.slave),
        .arr_rd_en_o     (arr_rd_en_o),
        .arr_index_o     (arr_index_o),
        .arr_tag_o       (arr_tag_o),
        .hit_i           (hit_i),
        .arr_block_i     (arr_block_i),
        .arr_wr_en_o     (arr_wr_en_o),
        .arr_wr_block_o  (arr_wr_block_o),
        .l2_req_valid_o  (l2_req_valid_o),
        .l2_req_ready_i  (l2_req_ready_i),
        .l2_addr_o       (l2_addr_o),
        .l2_beat_valid_i (l2_beat_valid_i),
        .l2_beat_i       (l2_beat_i)
    );

    always #5 clk_i = ~clk_i;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_wr = 0;
    int           exp_fills = 0;
    int           tb_cyc = 0;
    int           bp_until = 0;
    bit           rr_rand = 1'b0;
    exp_t         q[$];
    logic [127:0] mem[int unsigned];
    bit           cvld[64];
    logic [21:0]  ctag[64];
    logic [127:0] last_blk = '0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired, got timeout expected event", nm);
    endtask

    function automatic logic [127:0] get_mem(input int unsigned b);
        if (!mem.exists(b)) mem[b] = {$urandom, $urandom, $urandom, $urandom};
        return mem[b];
    endfunction

    // Misalignment rule from the load size and byte/word position.
    function automatic bit tb_mis(input int f3, input int off, input int wd);
`ifdef CACHE_LOAD_MISALIGN_CHECK_EN
        if ((f3 == 1 || f3 == 5) && off == 3) return 1'b1;
        if ((f3 == 2 || f3 == 6) && off != 0) return 1'b1;
        if (f3 == 3 && (off != 0 || wd == 3)) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Core response-ready driver with optional backpressure windows.
    initial begin
        core.resp_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            tb_cyc++;
            #1;
            if (tb_cyc < bp_until) core.resp_ready_i = 1'b0;
            else if (rr_rand) core.resp_ready_i = ($urandom % 3) != 0;
            else core.resp_ready_i = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (arr_wr_en_o) n_wr++;
        end
    end

    // Response monitor: pops the scoreboard on each accepted response.
    initial begin
        bit           held;
        logic [127:0] h_blk;
        logic [7:0]   h_f;
        exp_t         e;
        held = 1'b0;
        h_blk = '0;
        h_f = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                held = 1'b0;
                continue;
            end
            if (core.resp_valid_o) begin
                if (held) begin
                    chk("hold_block", core.ext_block_o, h_blk);
                    chk("hold_fields", {core.ext_offset_o, core.ext_word_o,
                        core.ext_funct3_o, core.resp_err_o}, h_f);
                end
                chk("busy_no_ready", core.req_ready_o, 0);
                if (core.resp_ready_i) begin
                    if (q.size() == 0) begin
                        bound_fail("resp_unexpected");
                    end else begin
                        e = q.pop_front();
                        chk("resp_block", core.ext_block_o, e.blk);
                        chk("resp_offset", core.ext_offset_o, e.off);
                        chk("resp_word", core.ext_word_o, e.word);
                        chk("resp_funct3", core.ext_funct3_o, e.f3);
                        chk("resp_err", core.resp_err_o, e.err);
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    h_blk = core.ext_block_o;
                    h_f = {core.ext_offset_o, core.ext_word_o,
                           core.ext_funct3_o, core.resp_err_o};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Waits for idle; stray beats arriving meanwhile must be ignored.
    task automatic wait_ready();
        int n;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (core.req_ready_o) break;
            n++;
            if (n > 100) begin
                bound_fail("ready_wait");
                break;
            end
            @(posedge clk_i);
            #1;
            l2_beat_valid_i = ($urandom % 2) == 1;
            l2_beat_i = $urandom;
        end
        l2_beat_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                           input int l2_dly, input int gap_at);
        int unsigned  b;
        int           idx;
        logic [21:0]  tg;
        bit           mis;
        bit           hit;
        logic [127:0] eb;
        int           ng;
        b = {a[31:4], 4'b0};
        idx = int'(a[9:4]);
        tg = a[31:10];
        mis = tb_mis(int'(f3), int'(a[1:0]), int'(a[3:2]));
        hit = !mis && cvld[idx] && ctag[idx] == tg;
        eb = mis ? last_blk : get_mem(b);
        last_blk = eb;
        q.push_back('{eb, a[1:0], a[3:2], f3, mis});
        wait_ready();
        core.req_valid_i = 1'b1;
        core.req_addr_i = a;
        core.req_funct3_i = f3;
        @(negedge clk_i);
        chk("accept_ready", core.req_ready_o, 1);
        chk("rd_en", arr_rd_en_o, !mis);
        if (!mis) chk("rd_index_tag", {arr_index_o, arr_tag_o}, {a[9:4], tg});
        @(posedge clk_i);
        #1;
        core.req_valid_i = 1'b0;
        if (!mis) begin
            hit_i = hit;
            arr_block_i = hit ? eb : {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk_i);
        if (mis) begin
            chk("err_resp_valid", core.resp_valid_o, 1);
            chk("err_no_traffic", {arr_rd_en_o, l2_req_valid_o}, 0);
            return;
        end
        chk("lookup_no_resp", core.resp_valid_o, 0);
        @(posedge clk_i);
        #1;
        hit_i = 1'b0;
        arr_block_i = {$urandom, $urandom, $urandom, $urandom};
        if (hit) begin
            @(negedge clk_i);
            chk("hit_latency", core.resp_valid_o, 1);
            return;
        end
        for (int d = 0; d < l2_dly; d++) begin
            @(negedge clk_i);
            chk("l2_req_wait", {l2_req_valid_o, l2_addr_o}, {1'b1, b});
            @(posedge clk_i);
            #1;
        end
        l2_req_ready_i = 1'b1;
        @(negedge clk_i);
        chk("l2_req", {l2_req_valid_o, l2_addr_o}, {1'b1, b});
        @(posedge clk_i);
        #1;
        l2_req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ng = (gap_at < 0) ? int'($urandom_range(0, 2)) : (k == gap_at ? 1 : 0);
            repeat (ng) begin
                @(negedge clk_i);
                chk("refill_no_wr", arr_wr_en_o, 0);
                @(posedge clk_i);
                #1;
            end
            l2_beat_valid_i = 1'b1;
            l2_beat_i = eb[32*k +: 32];
            @(negedge clk_i);
            chk("refill_no_wr", arr_wr_en_o, 0);
            @(posedge clk_i);
            #1;
            l2_beat_valid_i = 1'b0;
        end
        @(negedge clk_i);
        chk("fill_wr_en", arr_wr_en_o, 1);
        chk("fill_block", arr_wr_block_o, eb);
        chk("fill_index_tag", {arr_index_o, arr_tag_o}, {a[9:4], tg});
        exp_fills++;
        cvld[idx] = 1'b1;
        ctag[idx] = tg;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("miss_resp_valid", core.resp_valid_o, 1);
    endtask

    // Reset lands mid-refill after two beats; the load must vanish.
    task automatic reset_mid_refill(input logic [31:0] a);
        wait_ready();
        core.req_valid_i = 1'b1;
        core.req_addr_i = a;
        core.req_funct3_i = 3'b010;
        @(posedge clk_i);
        #1;
        core.req_valid_i = 1'b0;
        hit_i = 1'b0;
        @(posedge clk_i);
        #1;
        l2_req_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        l2_req_ready_i = 1'b0;
        repeat (2) begin
            l2_beat_valid_i = 1'b1;
            l2_beat_i = $urandom;
            @(posedge clk_i);
            #1;
        end
        rst_ni = 1'b0;
        repeat (3) begin
            l2_beat_i = $urandom;
            @(posedge clk_i);
            #1;
        end
        rst_ni = 1'b1;
        last_blk = '0;
        repeat (3) begin
            l2_beat_i = $urandom;
            @(negedge clk_i);
            chk("rst_idle_ready", core.req_ready_o, 1);
            chk("rst_no_fill", arr_wr_en_o, 0);
            chk("rst_quiet", {core.resp_valid_o, l2_req_valid_o}, 0);
            chk("rst_block_clear", core.ext_block_o, 0);
            @(posedge clk_i);
            #1;
        end
        l2_beat_valid_i = 1'b0;
    endtask

    initial begin
        int           acc_n;
        int           last_acc;
        bit           saw;
        logic [127:0] tmp;
        logic [31:0]  ra;
        core.req_valid_i = 1'b0;
        core.req_addr_i = '0;
        core.req_funct3_i = '0;
        hit_i = 1'b0;
        arr_block_i = '0;
        l2_req_ready_i = 1'b0;
        l2_beat_valid_i = 1'b0;
        l2_beat_i = '0;
        for (int i = 0; i < 64; i++) begin
            cvld[i] = 1'b0;
            ctag[i] = '0;
        end
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_ready", core.req_ready_o, 1);
        chk("reset_strobes", {arr_rd_en_o, arr_wr_en_o, l2_req_valid_o}, 0);
        chk("reset_resp", {core.resp_valid_o, core.resp_err_o}, 0);
        chk("reset_ext", {core.ext_block_o, core.ext_offset_o,
            core.ext_word_o, core.ext_funct3_o}, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_reset_ready", core.req_ready_o, 1);

        // Hit LW with DEADBEEF in word 2 of a preloaded line.
        tmp = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
        mem[32'h120] = tmp;
        cvld[6'h12] = 1'b1;
        ctag[6'h12] = '0;
        do_load(32'h0000_0124, 3'b010, 0, -1);

        // Miss LD with slow L2 acceptance and a gap before beat 2.
        mem[32'h1230] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        do_load(32'h0000_1230, 3'b011, 3, 2);

        // Hold off the response for several cycles.
        wait_ready();
        bp_until = tb_cyc + 10;
        do_load(32'h0000_0124, 3'b010, 0, -1);

        // Back-to-back hits with req_valid held high.
        wait_ready();
        core.req_valid_i = 1'b1;
        core.req_addr_i = 32'h0000_0128;
        core.req_funct3_i = 3'b010;
        acc_n = 0;
        last_acc = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_i);
            if (core.req_ready_o) begin
                if (last_acc >= 0) chk("b2b_spacing", c - last_acc, 3);
                last_acc = c;
                acc_n++;
                last_blk = get_mem(32'h120);
                q.push_back('{last_blk, 2'd0, 2'd2, 3'b010, 1'b0});
            end
            saw = arr_rd_en_o;
            @(posedge clk_i);
            #1;
            hit_i = saw;
            arr_block_i = get_mem(32'h120);
        end
        core.req_valid_i = 1'b0;
        hit_i = 1'b0;
        chk("b2b_count", acc_n, 5);

        // Misaligned LW and aligned LH on the same line.
        do_load(32'h0000_0125, 3'b010, 0, -1);
        do_load(32'h0000_0126, 3'b001, 0, -1);

        reset_mid_refill(32'h0000_0350);
        do_load(32'h0000_0350, 3'b000, 1, -1);

        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = {20'h0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 3)),
                  4'($urandom)};
            do_load(ra, 3'($urandom), int'($urandom_range(0, 3)), -1);
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk_i);
        chk("queue_drained", q.size(), 0);
        chk("fill_count", n_wr, exp_fills);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
